priority_encoder: RTL and testbench

- Registered priority encoder: reports the index of the highest-priority asserted bit of a request vector, plus a valid flag.
- Default configuration is 4 inputs, MSB wins, 2-bit index.
- Used wherever a one-of-N selection must be reduced to a binary index, e.g. interrupt or request arbitration front-ends.
- Outputs are registered: one clock of latency, async active-low reset.

---
 rtl/priority_encoder_pkg.sv | 9 +
 rtl/priority_encoder_core.sv | 39 +++
 rtl/priority_encoder.sv | 44 ++++
 tb/tb_priority_encoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_pkg.sv
// Shared helpers for the priority encoder: index-width derivation.
package priority_encoder_pkg;

  // Width of a binary index able to address `width` request lines (never below 1).
  function automatic int unsigned idx_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/priority_encoder_core.sv
// Combinational priority scan: winning index, any-request flag and one-hot of the winner.
module priority_encoder_core
  import priority_encoder_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter bit          LSB_PRIORITY = 1'b0,
  localparam int unsigned OUT_W       = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] data_input,
  output logic [OUT_W-1:0] index,
  output logic             valid,
  output logic [WIDTH-1:0] onehot
);

  always_comb begin
    index  = '0;
    onehot = '0;
    valid  = |data_input;
    // Scan so the preferred end is visited last; the last hit wins.
    if (LSB_PRIORITY) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (data_input[i]) begin
          index     = OUT_W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (data_input[i]) begin
          index     = OUT_W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/priority_encoder.sv
// Registered priority encoder: enable-qualified output stage over the combinational core.
module priority_encoder
  import priority_encoder_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter bit          LSB_PRIORITY = 1'b0,
  localparam int unsigned OUT_W       = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] data_input,
  output logic [OUT_W-1:0] encoded_output,
  output logic             valid_output,
  output logic [WIDTH-1:0] onehot_output
);

  logic [OUT_W-1:0] index_d;
  logic             valid_d;
  logic [WIDTH-1:0] onehot_d;

  priority_encoder_core #(
    .WIDTH        (WIDTH),
    .LSB_PRIORITY (LSB_PRIORITY)
  ) u_core (
    .data_input (data_input),
    .index      (index_d),
    .valid      (valid_d),
    .onehot     (onehot_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      encoded_output <= '0;
      valid_output   <= 1'b0;
      onehot_output  <= '0;
    end else if (en) begin
      encoded_output <= index_d;
      valid_output   <= valid_d;
      onehot_output  <= onehot_d;
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Scoreboard bench for priority_encoder: MSB-first, LSB-first and a 5-input instance.
module tb_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b1;
  logic [3:0] din4 = '0;
  logic [4:0] din5 = '0;

  logic [1:0] enc0, enc1;
  logic [2:0] enc2;
  logic       vld0, vld1, vld2;
  logic [3:0] oh0, oh1;
  logic [4:0] oh2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit done = 1'b0;

  typedef struct {
    string      name;
    int         dut;
    int         due;
    logic [2:0] enc;
    logic       vld;
    logic [4:0] oh;
  } exp_t;

  exp_t sb[$];

  priority_encoder #(.WIDTH(4), .LSB_PRIORITY(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .en(en), .data_input(din4),
    .encoded_output(enc0), .valid_output(vld0), .onehot_output(oh0)
  );

  priority_encoder #(.WIDTH(4), .LSB_PRIORITY(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .data_input(din4),
    .encoded_output(enc1), .valid_output(vld1), .onehot_output(oh1)
  );

  priority_encoder #(.WIDTH(5), .LSB_PRIORITY(1'b0)) u_w5 (
    .clk(clk), .rst_n(rst_n), .en(en), .data_input(din5),
    .encoded_output(enc2), .valid_output(vld2), .onehot_output(oh2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input string name, input int dut, input logic [2:0] enc,
                         input logic vld, input logic [4:0] oh);
    logic [2:0] a_enc;
    logic       a_vld;
    logic [4:0] a_oh;
    case (dut)
      0:       begin a_enc = {1'b0, enc0}; a_vld = vld0; a_oh = {1'b0, oh0}; end
      1:       begin a_enc = {1'b0, enc1}; a_vld = vld1; a_oh = {1'b0, oh1}; end
      default: begin a_enc = enc2;         a_vld = vld2; a_oh = oh2;         end
    endcase
    total++;
    if (a_enc !== enc || a_vld !== vld || a_oh !== oh) begin
      bad++;
      $display("FAIL %s (dut%0d): got enc=%0d vld=%b oh=%b, want enc=%0d vld=%b oh=%b",
               name, dut, a_enc, a_vld, a_oh, enc, vld, oh);
    end
  endtask

  task automatic push(input string name, input int dut, input int lag, input logic [2:0] enc,
                      input logic vld, input logic [4:0] oh);
    exp_t e;
    e.name = name; e.dut = dut; e.due = cyc + lag;
    e.enc = enc; e.vld = vld; e.oh = oh;
    sb.push_back(e);
  endtask

  // Outputs are sampled on the falling edge, well clear of the capturing rising edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        total++;
        bad++;
        $display("FAIL %s (dut%0d): check missed, due cycle %0d, now %0d", e.name, e.dut,
                 e.due, cyc);
      end else begin
        compare(e.name, e.dut, e.enc, e.vld, e.oh);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    compare("reset_async_msb", 0, 3'd0, 1'b0, 5'b00000);
    compare("reset_async_w5", 2, 3'd0, 1'b0, 5'b00000);
    step();
    step();
    compare("reset_held_lsb", 1, 3'd0, 1'b0, 5'b00000);

    rst_n = 1'b1;
    din4  = 4'b0000;
    push("empty_msb", 0, 1, 3'd0, 1'b0, 5'b00000);
    push("empty_w5", 2, 1, 3'd0, 1'b0, 5'b00000);

    for (int i = 0; i < 4; i++) begin
      step();
      din4 = 4'(1 << i);
      push("walk_msb", 0, 1, 3'(i), 1'b1, 5'(1 << i));
      push("walk_lsb", 1, 1, 3'(i), 1'b1, 5'(1 << i));
    end

    step();
    din4 = 4'b1111;
    din5 = 5'b10110;
    push("all_msb", 0, 1, 3'd3, 1'b1, 5'b01000);
    push("all_lsb", 1, 1, 3'd0, 1'b1, 5'b00001);
    push("w5_10110", 2, 1, 3'd4, 1'b1, 5'b10000);

    step();
    din4 = 4'b0110;
    din5 = 5'b00110;
    push("mid_msb", 0, 1, 3'd2, 1'b1, 5'b00100);
    push("mid_lsb", 1, 1, 3'd1, 1'b1, 5'b00010);
    push("w5_00110", 2, 1, 3'd2, 1'b1, 5'b00100);

    step();
    din4 = 4'b0100;
    push("pre_hold", 0, 1, 3'd2, 1'b1, 5'b00100);

    step();
    en   = 1'b0;
    din4 = 4'b0001;
    push("hold_1", 0, 1, 3'd2, 1'b1, 5'b00100);
    push("hold_2", 0, 2, 3'd2, 1'b1, 5'b00100);
    step();
    step();
    en = 1'b1;
    push("after_en", 0, 1, 3'd0, 1'b1, 5'b00001);

    step();
    din4 = 4'b1000;
    push("pre_reset", 0, 1, 3'd3, 1'b1, 5'b01000);
    step();
    step();

    // Mid-cycle reset must clear without waiting for a clock edge.
    rst_n = 1'b0;
    #1;
    compare("reset_mid_msb", 0, 3'd0, 1'b0, 5'b00000);
    compare("reset_mid_w5", 2, 3'd0, 1'b0, 5'b00000);
    din4 = 4'b1111;
    din5 = 5'b11111;
    step();
    step();
    compare("reset_ignores_in", 0, 3'd0, 1'b0, 5'b00000);
    rst_n = 1'b1;
    push("post_reset_msb", 0, 1, 3'd3, 1'b1, 5'b01000);
    push("post_reset_lsb", 1, 1, 3'd0, 1'b1, 5'b00001);

    step();
    step();
    step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout: got no end of stimulus, want end before 20000");
      $fatal(1);
    end
  end

endmodule
